dma_copy: RTL

DMA_COPY -- requirements
Module: dma_copy

---
 rtl/dma_copy.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_copy.sv
// Single-channel memory-to-memory copy engine: one bus read then one bus write per unit.
// Optional response timeout is built when DMA_TIMEOUT_EN is defined.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module dma_copy #(
    parameter int AW = 19,
    parameter int CW = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [AW-1:0]             src,
    input  logic [AW-1:0]             dst,
    input  logic [CW-1:0]             count,
    input  logic [`BUS_ACC_WIDTH-1:0] unit,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [AW-1:0]             addr,
    output logic                      w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [`BUS_WIDTH-1:0]     wdata,
    output logic                      req,
    input  logic [`BUS_WIDTH-1:0]     rdata,
    input  logic                      resp,
    input  logic                      fault
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t                    state, state_nxt;
    logic [AW-1:0]             src_q, dst_q, src_nxt, dst_nxt, step;
    logic [CW-1:0]             cnt_q, cnt_nxt;
    logic [`BUS_ACC_WIDTH-1:0] unit_q, unit_nxt;
    logic [`BUS_WIDTH-1:0]     buf_q, buf_nxt;
    logic                      done_nxt, err_nxt;

`ifdef DMA_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       tmo_hit;

    // tmo_q holds the number of wait cycles already spent without resp
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tmo_q <= 8'd0;
        else if ((state == RD_WAIT || state == WR_WAIT) && !resp)
            tmo_q <= tmo_q + 8'd1;
        else
            tmo_q <= 8'd0;
    end

    assign tmo_hit = (tmo_q == 8'd254);
`endif

    // Unknown access encodings are treated as word-sized
    always_comb begin
        case (unit_q)
            `BUS_ACC_1B: step = AW'(1);
            `BUS_ACC_2B: step = AW'(2);
            default:     step = AW'(4);
        endcase
    end

    always_comb begin
        state_nxt = state;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        cnt_nxt   = cnt_q;
        unit_nxt  = unit_q;
        buf_nxt   = buf_q;
        done_nxt  = 1'b0;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    err_nxt = 1'b0;
                    if (count != '0) begin
                        src_nxt   = src;
                        dst_nxt   = dst;
                        cnt_nxt   = count;
                        unit_nxt  = unit;
                        state_nxt = RD_REQ;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (fault) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (resp) begin
                    buf_nxt   = rdata;
                    state_nxt = WR_REQ;
                end
`ifdef DMA_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                end
`endif
            end
            WR_REQ: begin
                if (fault) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (resp) begin
                    src_nxt = src_q + step;
                    dst_nxt = dst_q + step;
                    cnt_nxt = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
`ifdef DMA_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
            unit_q <= '0;
            buf_q <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            src_q <= src_nxt;
            dst_q <= dst_nxt;
            cnt_q <= cnt_nxt;
            unit_q <= unit_nxt;
            buf_q <= buf_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Bus request fields load only on entry to a request state, so they stay put until resp
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req   <= 1'b0;
            addr  <= '0;
            w_rb  <= 1'b0;
            acc   <= '0;
            wdata <= '0;
        end else begin
            req <= (state_nxt == RD_REQ) || (state_nxt == WR_REQ);
            if (state_nxt == RD_REQ) begin
                addr <= src_nxt;
                w_rb <= 1'b0;
                acc  <= unit_nxt;
            end else if (state_nxt == WR_REQ) begin
                addr  <= dst_nxt;
                w_rb  <= 1'b1;
                acc   <= unit_nxt;
                wdata <= buf_nxt;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
